// File: rtl/log_fp_mult_serial_pkg.sv
// log_fp_pkg: shared state/class enums and Mitchell correction tables (used with LOG_MUL_CORRECTION_EN)
package log_fp_pkg;
  typedef enum logic [2:0] {S_COLLECT, S_DECODE, S_LOG, S_ADD, S_NORM, S_EMIT} state_t;
  typedef enum logic [1:0] {C_ZERO, C_NORM, C_INF, C_NAN} cls_t;
  localparam int LC [4] = '{2945, 5529, 4940, 2090};
  localparam int AC [4] = '{2260, 5126, 5426, 2688};
endpackage

// File: rtl/log_fp_mult_serial_if.sv
// log_fp_mult_serial_if: serial operand/result bus with valid/ready handshakes
interface log_fp_mult_serial_if #(parameter int BUS_W = 8);
  logic             in_valid;
  logic             in_ready;
  logic [BUS_W-1:0] in_a;
  logic [BUS_W-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [BUS_W-1:0] out_data;
  logic             out_last;
  modport master (output in_valid, in_a, in_b, out_ready, input in_ready, out_valid, out_data, out_last);
  modport slave  (input in_valid, in_a, in_b, out_ready, output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/log_fp_mult_serial_corr.sv
// log_fp_corr: piecewise Mitchell log/antilog mantissa correction, identity unless LOG_MUL_CORRECTION_EN
module log_fp_corr import log_fp_pkg::*; #(
  parameter int MAN_W = 10
) (
  input  logic             i_mode,
  input  logic [MAN_W-1:0] i_x,
  output logic [MAN_W-1:0] o_y
);
`ifdef LOG_MUL_CORRECTION_EN
  logic [1:0]       w_seg;
  logic [MAN_W-1:0] w_lc;
  logic [MAN_W-1:0] w_ac;
  logic [MAN_W:0]   w_add;
  assign w_seg = i_x[MAN_W-1 -: 2];
  assign w_lc  = MAN_W'(LC[w_seg] >>> (16 - MAN_W));
  assign w_ac  = MAN_W'(AC[w_seg] >>> (16 - MAN_W));
  assign w_add = {1'b0, i_x} + {1'b0, w_lc};
  // i_mode=0: log (saturating add), i_mode=1: antilog (clamped subtract)
  assign o_y = i_mode ? ((i_x > w_ac) ? i_x - w_ac : '0) : (w_add[MAN_W] ? '1 : w_add[MAN_W-1:0]);
`else
  logic w_unused;
  assign w_unused = i_mode;
  assign o_y = i_x;
`endif
endmodule

// File: rtl/log_fp_mult_serial.sv
// log_fp_mult_serial: byte-serial Mitchell log-domain FP multiplier; optional LOG_MUL_CORRECTION_EN
module log_fp_mult_serial import log_fp_pkg::*; #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int BUS_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  log_fp_mult_serial_if.slave  bus,
  output logic                 o_busy
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int BEATS = (W + BUS_W - 1) / BUS_W;
  localparam int PW    = BEATS * BUS_W;
  localparam int BW    = $clog2(BEATS + 1);
  localparam int EW    = EXP_W + 2;
  localparam logic [BW-1:0]        LAST = BW'(BEATS - 1);
  localparam logic [EXP_W-1:0]     EMAX = '1;
  localparam logic [EW-1:0]        BIAS = EW'(2 ** (EXP_W - 1) - 1);
  localparam logic signed [EW-1:0] EINF = EW'(2 ** EXP_W - 1);

  state_t                r_state;
  logic [BW-1:0]         r_beat;
  logic [PW-1:0]         r_a, r_b, r_res;
  logic                  r_s;
  cls_t                  r_ca, r_cb;
  logic [EXP_W-1:0]      r_ea, r_eb;
  logic [MAN_W-1:0]      r_ma, r_mb, r_la, r_lb, r_sum;
  logic signed [EW-1:0]  r_e;
  logic                  r_out_valid, r_out_last;
  logic [BUS_W-1:0]      r_out_data;
  logic [MAN_W-1:0]      w_la, w_lb, w_m;
  logic [MAN_W:0]        w_sum;
  logic [BW-1:0]         w_nbeat;
  logic                  w_nan, w_inf, w_zero;
  logic [W-1:0]          w_res;
  logic [PW-1:0]         w_res_p;
  logic                  w_unused;

  function automatic cls_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    return (e == '0) ? C_ZERO : (e != EMAX) ? C_NORM : (m == '0) ? C_INF : C_NAN;
  endfunction

  log_fp_corr #(.MAN_W(MAN_W)) u_corr_a (.i_mode(1'b0), .i_x(r_ma),  .o_y(w_la));
  log_fp_corr #(.MAN_W(MAN_W)) u_corr_b (.i_mode(1'b0), .i_x(r_mb),  .o_y(w_lb));
  log_fp_corr #(.MAN_W(MAN_W)) u_corr_n (.i_mode(1'b1), .i_x(r_sum), .o_y(w_m));

  assign w_unused     = ^{r_a, r_b};
  assign w_sum        = {1'b0, r_la} + {1'b0, r_lb};
  assign w_nbeat      = r_beat + 1'b1;
  assign bus.in_ready  = (r_state == S_COLLECT);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign o_busy        = (r_state != S_COLLECT) || (r_beat != '0);

  // result packing: specials first, then exponent saturation/flush, else normal result
  always_comb begin
    w_nan   = (r_ca == C_NAN) || (r_cb == C_NAN) || (r_ca == C_INF && r_cb == C_ZERO) || (r_ca == C_ZERO && r_cb == C_INF);
    w_inf   = (r_ca == C_INF) || (r_cb == C_INF);
    w_zero  = (r_ca == C_ZERO) || (r_cb == C_ZERO);
    w_res   = w_nan ? {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}} :
              (w_inf || (!w_zero && r_e >= EINF)) ? {r_s, EMAX, {MAN_W{1'b0}}} :
              (w_zero || r_e[EW-1] || r_e == '0) ? {r_s, {(W-1){1'b0}}} :
              {r_s, r_e[EXP_W-1:0], w_m};
    w_res_p = PW'(w_res);
  end

  // operation FSM: collect slices, four pipeline steps, then emit slices
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state     <= S_COLLECT;
      r_beat      <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_s         <= 1'b0;
      r_ca        <= C_ZERO;
      r_cb        <= C_ZERO;
      r_ea        <= '0;
      r_eb        <= '0;
      r_ma        <= '0;
      r_mb        <= '0;
      r_la        <= '0;
      r_lb        <= '0;
      r_sum       <= '0;
      r_e         <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        S_COLLECT: if (bus.in_valid) begin
          r_a[r_beat*BUS_W +: BUS_W] <= bus.in_a;
          r_b[r_beat*BUS_W +: BUS_W] <= bus.in_b;
          r_beat  <= (r_beat == LAST) ? '0 : w_nbeat;
          r_state <= (r_beat == LAST) ? S_DECODE : S_COLLECT;
        end
        S_DECODE: begin
          r_s     <= r_a[W-1] ^ r_b[W-1];
          r_ea    <= r_a[W-2 -: EXP_W];
          r_eb    <= r_b[W-2 -: EXP_W];
          r_ma    <= r_a[MAN_W-1:0];
          r_mb    <= r_b[MAN_W-1:0];
          r_ca    <= classify(r_a[W-2 -: EXP_W], r_a[MAN_W-1:0]);
          r_cb    <= classify(r_b[W-2 -: EXP_W], r_b[MAN_W-1:0]);
          r_state <= S_LOG;
        end
        S_LOG: begin
          r_la    <= w_la;
          r_lb    <= w_lb;
          r_state <= S_ADD;
        end
        S_ADD: begin
          r_sum   <= w_sum[MAN_W-1:0];
          r_e     <= {2'b0, r_ea} + {2'b0, r_eb} - BIAS + EW'(w_sum[MAN_W]);
          r_state <= S_NORM;
        end
        S_NORM: begin
          r_res       <= w_res_p;
          r_out_data  <= w_res_p[BUS_W-1:0];
          r_out_valid <= 1'b1;
          r_out_last  <= (LAST == '0);
          r_beat      <= '0;
          r_state     <= S_EMIT;
        end
        S_EMIT: if (bus.out_ready) begin
          r_beat      <= (r_beat == LAST) ? '0 : w_nbeat;
          r_out_valid <= (r_beat != LAST);
          r_out_last  <= (r_beat != LAST) && (w_nbeat == LAST);
          r_out_data  <= (r_beat == LAST) ? '0 : r_res[w_nbeat*BUS_W +: BUS_W];
          r_state     <= (r_beat == LAST) ? S_COLLECT : S_EMIT;
        end
        default: r_state <= S_COLLECT;
      endcase
    end
endmodule

// File: tb/tb_log_fp_mult_serial.sv
// tb_log_fp_mult_serial: directed self-checking bench for log_fp_mult_serial (default params)
module tb_log_fp_mult_serial;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  int   checks = 0;
  int   failures = 0;

  log_fp_mult_serial_if #(.BUS_W(8)) bus();
  log_fp_mult_serial #(.EXP_W(5), .MAN_W(10), .BUS_W(8)) dut (.clk(clk), .rst(rst), .bus(bus), .o_busy(busy));

  always #5 clk = ~clk;

`ifdef LOG_MUL_CORRECTION_EN
  localparam logic [15:0] E_15X15 = 16'h4077;
  localparam logic [15:0] E_2X3   = 16'h4627;
  localparam logic [15:0] E_1X1   = 16'h3C39;
`else
  localparam logic [15:0] E_15X15 = 16'h4000;
  localparam logic [15:0] E_2X3   = 16'h4600;
  localparam logic [15:0] E_1X1   = 16'h3C00;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input int nbeats, input bit rnd);
    for (int i = 0; i < nbeats; i++) begin
      if (rnd) repeat ($urandom_range(0, 3)) tick();
      bus.in_valid = 1'b1;
      bus.in_a     = a[i*8 +: 8];
      bus.in_b     = b[i*8 +: 8];
      tick();
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp, input bit rnd, input bit hold, input bit junk);
    logic [15:0] r;
    logic [7:0]  d0;
    int          lat;
    int          w;
    r = '0;
    send(a, b, 2, rnd);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin tick(); lat++; end
    chk({tag, "_latency"}, lat, 5);
    if (junk) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 8'hFF;
      bus.in_b     = 8'hFF;
      chk({tag, "_in_ready_emit"}, bus.in_ready, 0);
    end
    if (hold) begin
      d0 = bus.out_data;
      repeat (3) begin
        tick();
        chk({tag, "_hold_data"}, bus.out_data, d0);
        chk({tag, "_hold_last"}, bus.out_last, 0);
      end
    end
    for (int i = 0; i < 2; i++) begin
      w = 0;
      while (!bus.out_valid && w < 20) begin tick(); w++; end
      chk({tag, "_valid"}, bus.out_valid, 1);
      chk({tag, "_last"}, bus.out_last, (i == 1) ? 1 : 0);
      r[i*8 +: 8] = bus.out_data;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    bus.in_valid = 1'b0;
    chk({tag, "_result"}, r, exp);
    chk({tag, "_idle"}, {bus.out_valid, busy, bus.in_ready}, 3'b001);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk) rst = 1'b0;
    tick();

    run_op("exact_1p5sq", 16'h3E00, 16'h3E00, E_15X15, 0, 0, 0);
    run_op("two_x_three", 16'h4000, 16'h4200, E_2X3, 0, 0, 0);
    run_op("zero_x_neg", 16'h0000, 16'hC000, 16'h8000, 0, 0, 0);
    run_op("inf_x_zero", 16'h7C00, 16'h0000, 16'h7E00, 0, 0, 0);
    run_op("inf_x_neg", 16'h7C00, 16'hBC00, 16'hFC00, 0, 0, 0);
    run_op("nan_x_one", 16'h7E01, 16'h3C00, 16'h7E00, 0, 0, 0);
    run_op("overflow", 16'h7800, 16'h7800, 16'h7C00, 0, 0, 0);
    run_op("underflow", 16'h0400, 16'h0400, 16'h0000, 0, 0, 0);
    run_op("gaps", 16'h3E00, 16'h3E00, E_15X15, 1, 0, 0);
    run_op("backpressure", 16'h4000, 16'h4200, E_2X3, 0, 1, 0);
    run_op("emit_in_valid", 16'h3C00, 16'h3C00, E_1X1, 0, 0, 1);
    run_op("after_junk", 16'h0000, 16'hC000, 16'h8000, 0, 0, 0);

    send(16'h3C00, 16'h3C00, 1, 0);
    chk("partial_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_partial_busy", busy, 0);
    chk("rst_partial_in_ready", bus.in_ready, 1);
    @(negedge clk) rst = 1'b0;
    tick();

    send(16'h7800, 16'h7800, 2, 0);
    repeat (4) tick();
    chk("emit_reached", bus.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_emit_valid", bus.out_valid, 0);
    chk("rst_emit_data", bus.out_data, 0);
    chk("rst_emit_last", bus.out_last, 0);
    chk("rst_emit_busy", busy, 0);
    chk("rst_emit_in_ready", bus.in_ready, 1);
    @(negedge clk) rst = 1'b0;
    tick();

    run_op("after_reset", 16'h3C00, 16'h3C00, E_1X1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
